hazard_fwd_unit: RTL and testbench
==================================

Name: hazard_fwd_unit

Overview:
- Parametrised hazard-detection and forwarding controller for the pipelined MIPS datapath.
- Replaces the fixed-depth hazard and forwarding logic with a tag pipeline that tracks in-flight register writes across STAGES post-decode registers.
- Supports per-class result latency (ALU vs load), NUM_SRC source operands, external freeze, and flush.
- Sits beside the decode stage: decides stall per issue, and delivers registered forwarding selects aligned with the execute stage.

Parameters:
REG_AW, 5, register address width; register 0 is hard-wired zero.
NUM_SRC, 2, source operands checked per instruction.
STAGES, 3, tracked pipeline registers after decode (1=ID/EX, 2=EX/MEM, 3=MEM/WB).
ALU_READY, 2, stage index from which an ALU result is forwardable.
LOAD_READY, 3, stage index from which a load result is forwardable; must satisfy ALU_READY <= LOAD_READY <= STAGES.
SEL_W, $clog2(STAGES+1), width of one forward select.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
id_valid  in  1  decode slot holds a real instruction.
id_dst  in  REG_AW  destination register of the decode instruction.
id_wen  in  1  decode instruction writes a register.
id_is_load  in  1  decode instruction is a load.
id_src  in  NUM_SRC*REG_AW  source addresses, operand i at bits [i*REG_AW +: REG_AW].
id_src_used  in  NUM_SRC  operand i is actually read.
freeze  in  1  downstream stall; whole tag pipe holds.
flush  in  1  kill decode instruction (taken branch/jump).
stall  out  1  combinational; hold PC and IF/ID, inject bubble.
issue  out  1  combinational; id_valid & ~stall & ~flush & ~freeze.
ex_fwd_sel  out  NUM_SRC*SEL_W  registered; per operand 0 = register-file value, k = value from stage k.
tag_busy  out  STAGES  valid&wen bit of each tracked stage (debug).

Behaviour:
- Reset (rst low, async): all stage entries invalid, ex_fwd_sel = 0, tag_busy = 0. stall is 0 because no entries are valid.
- Entry per stage: valid, dst, wen, is_load. Entries with dst=0 or wen=0 never match.
- Shift on each rising edge when freeze=0:
  - Stage k+1 <= stage k; the oldest entry is dropped.
  - Stage 1 <= decode instruction if issue=1, otherwise a bubble (valid=0).
  - With freeze=1, every entry and ex_fwd_sel hold.
- Match: operand i (id_src_used[i]=1, addr!=0) matches stage k if the entry is valid, wen=1 and dst equal. Only the youngest (lowest k) match is considered.
- Readiness: the decode instruction reads operands one cycle later, when that entry sits at k+1. The match is ready iff k+1 >= (is_load ? LOAD_READY : ALU_READY).
- stall = id_valid & ~flush & (any operand's youngest match is not ready).
- If k+1 > STAGES, the value has already been written back and operand selects 0. The register file is write-before-read.
- Forward select: on an edge with issue=1, ex_fwd_sel[i] <= (youngest ready match ? k+1 : 0). Otherwise, with freeze=0, it is cleared to 0.
- Simultaneous events:
  - flush overrides stall: bubble inserted, stall=0.
  - freeze with a hazard: stall may assert, but nothing shifts.
  - Reset mid-operation discards all in-flight tags immediately.
- Default parameters give the classic behaviour: load-use = 1 stall cycle, ALU-ALU = 0 stalls.

Optional Feature:
- Macro HFU_STALL_CNT_EN adds the output port stall_cnt (32 bits).
- stall_cnt counts cycles with stall=1 & freeze=0, saturating at 32'hFFFF_FFFF, and is cleared by reset.
- Without the macro, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Back-to-back ALU ops: issue add r3 (wen, not load), then next cycle sub reading r3 -> stall=0, ex_fwd_sel[0]=2 one edge later.
- Load-use: issue lw r5, next instruction reads r5 -> stall=1 for exactly 1 cycle, then issue=1 with ex_fwd_sel=3; HFU_STALL_CNT_EN stall_cnt=1.
- Youngest wins: stage1 writes r4 (ALU) and stage2 writes r4 (ALU); decode reads r4 -> ex_fwd_sel=2 (from the stage1 entry), not 3.
- r0 and unused: decode reads r0, or id_src_used=0, while stage1 is a load to r0 -> stall=0, ex_fwd_sel=0.
- Flush and freeze: flush=1 during a load-use hazard -> stall=0, issue=0, bubble enters stage1. freeze=1 for 3 cycles -> tag_busy and ex_fwd_sel unchanged.
- Async reset: rst low mid-stream between edges -> tag_busy=0, ex_fwd_sel=0 and stall=0 without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_fwd_unit_if.sv
// Decode-side bus of hazard_fwd_unit.
//   master : decode stage; drives the decode instruction, freeze and flush, and
//            receives stall/issue, the execute-aligned forward selects and tag_busy.
//   slave  : hazard_fwd_unit.
interface hazard_fwd_unit_if #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned STAGES  = 3,
  parameter int unsigned SEL_W   = $clog2(STAGES + 1)
) ();
  logic                      id_valid;
  logic [REG_AW-1:0]         id_dst;
  logic                      id_wen;
  logic                      id_is_load;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_used;
  logic                      freeze;
  logic                      flush;
  logic                      stall;
  logic                      issue;
  logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel;
  logic [STAGES-1:0]         tag_busy;

  modport master (
    output id_valid, id_dst, id_wen, id_is_load, id_src, id_src_used, freeze, flush,
    input  stall, issue, ex_fwd_sel, tag_busy
  );

  modport slave (
    input  id_valid, id_dst, id_wen, id_is_load, id_src, id_src_used, freeze, flush,
    output stall, issue, ex_fwd_sel, tag_busy
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding controller for the pipelined MIPS datapath.
// A tag pipe of STAGES entries (valid, dst, wen, is_load) mirrors the post-decode
// pipeline registers. Each decode operand is compared against the tags; the youngest
// match decides whether decode must stall or which stage the execute stage forwards from.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   bus        hazard_fwd_unit_if.slave: decode instruction, freeze, flush in;
//              stall/issue (combinational), ex_fwd_sel (registered), tag_busy out
//   stall_cnt  (only with HFU_STALL_CNT_EN) saturating count of stall&~freeze cycles
//
// Optional feature macro: HFU_STALL_CNT_EN.
module hazard_fwd_unit #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned STAGES     = 3,
  parameter int unsigned ALU_READY  = 2,
  parameter int unsigned LOAD_READY = 3,
  parameter int unsigned SEL_W      = $clog2(STAGES + 1)
) (
  input logic               clk,
  input logic               rst,
  hazard_fwd_unit_if.slave  bus
`ifdef HFU_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  logic [STAGES-1:0]             valid_q, valid_d;
  logic [STAGES-1:0]             wen_q, wen_d;
  logic [STAGES-1:0]             load_q, load_d;
  logic [STAGES-1:0][REG_AW-1:0] dst_q, dst_d;
  logic [NUM_SRC*SEL_W-1:0]      fwd_sel_q, fwd_sel_d;

  logic                     hazard;
  logic                     stall;
  logic                     issue;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic [REG_AW-1:0]        src;
  logic                     found;
  logic                     hit_load;
  int unsigned              hit_k;
  int unsigned              need;

  // Operand match: the youngest (lowest k) matching stage wins.
  always_comb begin
    hazard   = 1'b0;
    fwd_sel  = '0;
    src      = '0;
    found    = 1'b0;
    hit_load = 1'b0;
    hit_k    = 0;
    need     = 0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src      = bus.id_src[i*REG_AW +: REG_AW];
      found    = 1'b0;
      hit_load = 1'b0;
      hit_k    = 0;
      for (int unsigned k = 1; k <= STAGES; k++) begin
        if (!found && bus.id_src_used[i] && (src != '0) && valid_q[k-1] && wen_q[k-1] &&
            (dst_q[k-1] == src)) begin
          found    = 1'b1;
          hit_k    = k;
          hit_load = load_q[k-1];
        end
      end
      need = hit_load ? LOAD_READY : ALU_READY;
      // The operand is read one cycle later, when the producer sits at k+1.
      if (found && (hit_k + 1 < need)) begin
        hazard = 1'b1;
      end else if (found && (hit_k + 1 <= STAGES)) begin
        fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(hit_k + 1);
      end
      // Beyond the last stage the register file already holds the value: select 0.
    end
  end

  assign stall = bus.id_valid & ~bus.flush & hazard;
  assign issue = bus.id_valid & ~stall & ~bus.flush & ~bus.freeze;

  assign bus.stall      = stall;
  assign bus.issue      = issue;
  assign bus.ex_fwd_sel = fwd_sel_q;
  assign bus.tag_busy   = valid_q & wen_q;

  always_comb begin
    valid_d   = valid_q;
    wen_d     = wen_q;
    load_d    = load_q;
    dst_d     = dst_q;
    fwd_sel_d = fwd_sel_q;
    if (!bus.freeze) begin
      for (int unsigned j = STAGES - 1; j >= 1; j--) begin
        valid_d[j] = valid_q[j-1];
        wen_d[j]   = wen_q[j-1];
        load_d[j]  = load_q[j-1];
        dst_d[j]   = dst_q[j-1];
      end
      valid_d[0] = issue;
      wen_d[0]   = bus.id_wen;
      load_d[0]  = bus.id_is_load;
      dst_d[0]   = bus.id_dst;
      fwd_sel_d  = issue ? fwd_sel : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= '0;
      wen_q     <= '0;
      load_q    <= '0;
      dst_q     <= '0;
      fwd_sel_q <= '0;
    end else begin
      valid_q   <= valid_d;
      wen_q     <= wen_d;
      load_q    <= load_d;
      dst_q     <= dst_d;
      fwd_sel_q <= fwd_sel_d;
    end
  end

`ifdef HFU_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !bus.freeze && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit with default parameters.
module tb_hazard_fwd_unit;

  localparam int unsigned REG_AW  = 5;
  localparam int unsigned NUM_SRC = 2;
  localparam int unsigned STAGES  = 3;
  localparam int unsigned SEL_W   = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  hazard_fwd_unit_if #(
    .REG_AW (REG_AW),
    .NUM_SRC(NUM_SRC),
    .STAGES (STAGES),
    .SEL_W  (SEL_W)
  ) bus ();

`ifdef HFU_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  hazard_fwd_unit #(
    .REG_AW    (REG_AW),
    .NUM_SRC   (NUM_SRC),
    .STAGES    (STAGES),
    .ALU_READY (2),
    .LOAD_READY(3),
    .SEL_W     (SEL_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave)
`ifdef HFU_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a decode instruction; settles combinational outputs before returning.
  task automatic set_id(input logic v, input logic [4:0] dst, input logic wen,
                        input logic ld, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] used);
    bus.id_valid    = v;
    bus.id_dst      = dst;
    bus.id_wen      = wen;
    bus.id_is_load  = ld;
    bus.id_src      = {s1, s0};
    bus.id_src_used = used;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
    for (int i = 0; i < 3; i++) tick();
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst        = 1'b0;
    bus.freeze = 1'b0;
    bus.flush  = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
    #1;
    check_eq("reset_tag_busy", 32'(bus.tag_busy), 32'h0);
    check_eq("reset_fwd_sel", 32'(bus.ex_fwd_sel), 32'h0);
    check_eq("reset_stall", 32'(bus.stall), 32'h0);
    tick();
    rst = 1'b1;

    // Back-to-back ALU: add r3 then sub reading r3.
    set_id(1'b1, 5'd3, 1'b1, 1'b0, 5'd1, 5'd2, 2'b11);
    check_eq("alu_first_stall", 32'(bus.stall), 32'h0);
    check_eq("alu_first_issue", 32'(bus.issue), 32'h1);
    tick();
    check_eq("alu_first_busy", 32'(bus.tag_busy), 32'h1);
    set_id(1'b1, 5'd6, 1'b1, 1'b0, 5'd3, 5'd7, 2'b11);
    check_eq("alu_use_stall", 32'(bus.stall), 32'h0);
    tick();
    check_eq("alu_use_sel", 32'(bus.ex_fwd_sel), 32'h2);
    check_eq("alu_use_busy", 32'(bus.tag_busy), 32'h3);
    drain();
    check_eq("drain_busy", 32'(bus.tag_busy), 32'h0);
    check_eq("drain_sel", 32'(bus.ex_fwd_sel), 32'h0);

    // Load-use: lw r5 then add r8 reading r5.
    set_id(1'b1, 5'd5, 1'b1, 1'b1, 5'd1, 5'd0, 2'b01);
    tick();
    set_id(1'b1, 5'd8, 1'b1, 1'b0, 5'd5, 5'd0, 2'b01);
    check_eq("lu_stall", 32'(bus.stall), 32'h1);
    check_eq("lu_issue", 32'(bus.issue), 32'h0);
    tick();
    check_eq("lu_bubble_busy", 32'(bus.tag_busy), 32'h2);
    check_eq("lu_bubble_sel", 32'(bus.ex_fwd_sel), 32'h0);
    check_eq("lu_retry_stall", 32'(bus.stall), 32'h0);
    check_eq("lu_retry_issue", 32'(bus.issue), 32'h1);
    tick();
    check_eq("lu_sel", 32'(bus.ex_fwd_sel), 32'h3);
    check_eq("lu_busy", 32'(bus.tag_busy), 32'h5);
    drain();
`ifdef HFU_STALL_CNT_EN
    check_eq("lu_stall_cnt", stall_cnt, 32'd1);
`endif

    // Youngest wins: two ALU writes to r4, then a reader in operand 1.
    set_id(1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
    tick();
    set_id(1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
    tick();
    set_id(1'b1, 5'd9, 1'b1, 1'b0, 5'd1, 5'd4, 2'b11);
    check_eq("young_stall", 32'(bus.stall), 32'h0);
    tick();
    check_eq("young_sel", 32'(bus.ex_fwd_sel), 32'h8);
    drain();

    // r0 and unused operands never match.
    set_id(1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
    tick();
    set_id(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 2'b11);
    check_eq("r0_stall", 32'(bus.stall), 32'h0);
    tick();
    check_eq("r0_sel", 32'(bus.ex_fwd_sel), 32'h0);
    drain();
    set_id(1'b1, 5'd9, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
    tick();
    set_id(1'b1, 5'd7, 1'b1, 1'b0, 5'd9, 5'd9, 2'b00);
    check_eq("unused_stall", 32'(bus.stall), 32'h0);
    tick();
    check_eq("unused_sel", 32'(bus.ex_fwd_sel), 32'h0);
    drain();

    // Flush during load-use hazard.
    set_id(1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
    tick();
    set_id(1'b1, 5'd8, 1'b1, 1'b0, 5'd5, 5'd0, 2'b01);
    bus.flush = 1'b1;
    #1;
    check_eq("flush_stall", 32'(bus.stall), 32'h0);
    check_eq("flush_issue", 32'(bus.issue), 32'h0);
    tick();
    bus.flush = 1'b0;
    #1;
    check_eq("flush_busy", 32'(bus.tag_busy), 32'h2);
    tick();
    check_eq("post_flush_sel", 32'(bus.ex_fwd_sel), 32'h3);
    check_eq("post_flush_busy", 32'(bus.tag_busy), 32'h5);

    // Freeze for three edges: state holds.
    set_id(1'b1, 5'd10, 1'b1, 1'b1, 5'd8, 5'd0, 2'b01);
    bus.freeze = 1'b1;
    #1;
    check_eq("freeze_issue", 32'(bus.issue), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("freeze_busy", 32'(bus.tag_busy), 32'h5);
      check_eq("freeze_sel", 32'(bus.ex_fwd_sel), 32'h3);
    end
    bus.freeze = 1'b0;
    #1;
    tick();
    check_eq("unfreeze_sel", 32'(bus.ex_fwd_sel), 32'h2);
    check_eq("unfreeze_busy", 32'(bus.tag_busy), 32'h3);

    // Async reset mid-cycle while a load-use hazard is pending.
    set_id(1'b1, 5'd11, 1'b1, 1'b0, 5'd10, 5'd0, 2'b01);
    check_eq("pre_rst_stall", 32'(bus.stall), 32'h1);
`ifdef HFU_STALL_CNT_EN
    check_eq("pre_rst_cnt", stall_cnt, 32'd1);
`endif
    #2;
    rst = 1'b0;
    #1;
    check_eq("rst_busy", 32'(bus.tag_busy), 32'h0);
    check_eq("rst_sel", 32'(bus.ex_fwd_sel), 32'h0);
    check_eq("rst_stall", 32'(bus.stall), 32'h0);
`ifdef HFU_STALL_CNT_EN
    check_eq("rst_cnt", stall_cnt, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
